gauss_window_ctrl: RTL and testbench

Raster-scan scheduler for the 3x3 Gaussian `computing_block`. It counts pixels accepted into the shared 3-line pixel buffer, decides when each output window is complete, and emits the window centre coordinates with the matching `corner_type` code. It also throttles input so that pixels still needed by a pending window are never overwritten. It sits between the pixel source, the line-buffer address logic and the computing datapath.

---
 rtl/gauss_window_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_gauss_window_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gauss_window_ctrl.sv
// ---------------------------------------------------------------------------------------------
// gauss_window_ctrl
//
// Raster-scan scheduler for the 3x3 Gaussian computing_block. Counts pixels written into the
// shared pixel buffer, decides when each output window is complete, presents the window centre
// with its corner_type kernel selector, and throttles input so a pixel still needed by a
// pending window is never overwritten.
//
// Optional feature: define GAUSS_CTRL_ABORT_EN to make `abort` cancel a running frame.
// Without it the abort port exists but is ignored.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start        frame start request, honoured only in IDLE
//   abort        frame abort request (only with GAUSS_CTRL_ABORT_EN)
//   in_valid     source holds a pixel
//   in_ready     pixel accepted this cycle when in_valid is also high
//   wr_idx       linear index of the pixel being accepted
//   win_valid    window at (win_row, win_col) is complete in the buffer
//   win_ready    datapath consumes the window
//   win_row      window centre row
//   win_col      window centre column
//   corner_type  kernel selector (0 outside RUN)
//   busy         high while a frame is running
//   done         one-cycle pulse after the last window is consumed
// ---------------------------------------------------------------------------------------------
module gauss_window_ctrl #(
   parameter int unsigned IMG_WIDTH  = 8,
   parameter int unsigned IMG_HEIGHT = 8,
   parameter int unsigned BUF_DEPTH  = 3 * IMG_WIDTH,
   localparam int unsigned COL_W = $clog2(IMG_WIDTH),
   localparam int unsigned ROW_W = $clog2(IMG_HEIGHT),
   localparam int unsigned IDX_W = $clog2(IMG_WIDTH * IMG_HEIGHT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [IDX_W-1:0] wr_idx,
   output logic             win_valid,
   input  logic             win_ready,
   output logic [ROW_W-1:0] win_row,
   output logic [COL_W-1:0] win_col,
   output logic [3:0]       corner_type,
   output logic             busy,
   output logic             done
);

   localparam int unsigned N_PIX = IMG_WIDTH * IMG_HEIGHT;
   // Two spare bits so need and the throttle sums can never wrap.
   localparam int unsigned SUM_W = IDX_W + 2;

   localparam logic [SUM_W-1:0] N_EXT  = SUM_W'(N_PIX);
   localparam logic [SUM_W-1:0] D_EXT  = SUM_W'(BUF_DEPTH);
   localparam logic [SUM_W-1:0] W1_EXT = SUM_W'(IMG_WIDTH + 1);
   localparam logic [SUM_W-1:0] W2_EXT = SUM_W'(IMG_WIDTH + 2);

   localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(N_PIX);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] acc_cnt_q, acc_cnt_d;
   logic [IDX_W-1:0] out_idx_q, out_idx_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [COL_W-1:0] col_q, col_d;

   logic             run;
   logic [SUM_W-1:0] acc_ext;
   logic [SUM_W-1:0] out_ext;
   logic [SUM_W-1:0] need_raw;
   logic [SUM_W-1:0] need;
   logic             accept;
   logic             consume;

`ifndef GAUSS_CTRL_ABORT_EN
   logic unused_abort;
   assign unused_abort = abort;
`endif

   // ------------------------------------------------------------------------------------------
   // Decode from registered state only: no path from in_valid or win_ready to the handshakes.
   // ------------------------------------------------------------------------------------------
   assign run     = (state_q == StRun);
   assign acc_ext = {2'b00, acc_cnt_q};
   assign out_ext = {2'b00, out_idx_q};

   // The last column has no right neighbour, so its window completes one pixel earlier.
   assign need_raw = out_ext + ((col_q == COL_LAST) ? W1_EXT : W2_EXT);
   assign need     = (need_raw > N_EXT) ? N_EXT : need_raw;

   // Keep pixel (r-1, c-1) of the pending window alive in the circular buffer.
   assign in_ready  = run && (acc_ext < N_EXT) && ((acc_ext + W1_EXT) < (out_ext + D_EXT));
   assign win_valid = run && (acc_ext >= need);

   assign accept  = in_valid & in_ready;
   assign consume = win_valid & win_ready;

   assign wr_idx  = acc_cnt_q;
   assign win_row = row_q;
   assign win_col = col_q;
   assign busy    = run;
   assign done    = (state_q == StDone);

   always_comb begin
      corner_type = 4'd0;
      if (run) begin
         if (row_q == '0) begin
            if (col_q == '0) begin
               corner_type = 4'd1;
            end else if (col_q == COL_LAST) begin
               corner_type = 4'd2;
            end else begin
               corner_type = 4'd8;
            end
         end else if (row_q == ROW_LAST) begin
            if (col_q == '0) begin
               corner_type = 4'd5;
            end else if (col_q == COL_LAST) begin
               corner_type = 4'd6;
            end else begin
               corner_type = 4'd8;
            end
         end else begin
            if (col_q == '0) begin
               corner_type = 4'd3;
            end else if (col_q == COL_LAST) begin
               corner_type = 4'd4;
            end else begin
               corner_type = 4'd8;
            end
         end
      end
   end

   // ------------------------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      acc_cnt_d = acc_cnt_q;
      out_idx_d = out_idx_q;
      row_d     = row_q;
      col_d     = col_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StRun;
               acc_cnt_d = '0;
               out_idx_d = '0;
               row_d     = '0;
               col_d     = '0;
            end
         end

         StRun: begin
            if (accept && (acc_cnt_q != N_IDX)) begin
               acc_cnt_d = acc_cnt_q + IDX_ONE;
            end
            if (consume) begin
               out_idx_d = out_idx_q + IDX_ONE;
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  row_d = row_q + ROW_ONE;
               end else begin
                  col_d = col_q + COL_ONE;
               end
               if (out_idx_q == LAST_IDX) begin
                  state_d = StDone;
                  // Park the coordinates so win_row never shows an out-of-frame row.
                  row_d   = '0;
                  col_d   = '0;
               end
            end
`ifdef GAUSS_CTRL_ABORT_EN
            // Abort overrides any accept or consume in the same cycle.
            if (abort) begin
               state_d   = StIdle;
               acc_cnt_d = '0;
               out_idx_d = '0;
               row_d     = '0;
               col_d     = '0;
            end
`endif
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         acc_cnt_q <= '0;
         out_idx_q <= '0;
         row_q     <= '0;
         col_q     <= '0;
      end else begin
         state_q   <= state_d;
         acc_cnt_q <= acc_cnt_d;
         out_idx_q <= out_idx_d;
         row_q     <= row_d;
         col_q     <= col_d;
      end
   end

endmodule

// File: tb/tb_gauss_window_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_gauss_window_ctrl
//
// Scoreboard bench for gauss_window_ctrl at W=4, H=3, D=12. The stimulus side pushes the
// expected window sequence when it issues start; a negedge monitor keeps a counting model of
// the frame (pixels in, windows out) and compares handshakes, coordinates and corner codes.
// ---------------------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gauss_window_ctrl;

   localparam int W     = 4;
   localparam int H     = 3;
   localparam int D     = 12;
   localparam int N     = W * H;
   localparam int IDX_W = $clog2(N + 1);

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             abort;
   logic             in_valid;
   logic             in_ready;
   logic [IDX_W-1:0] wr_idx;
   logic             win_valid;
   logic             win_ready;
   logic [1:0]       win_row;
   logic [1:0]       win_col;
   logic [3:0]       corner_type;
   logic             busy;
   logic             done;

   gauss_window_ctrl #(
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H),
      .BUF_DEPTH (D)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .wr_idx     (wr_idx),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_row    (win_row),
      .win_col    (win_col),
      .corner_type(corner_type),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   // Expected windows packed as row*256 + col*16 + corner.
   int exp_q[$];
   int corner_tab[N] = '{1, 8, 8, 2, 3, 8, 8, 4, 5, 8, 8, 6};

   // Frame model state, advanced by the monitor.
   int m_state = M_IDLE;
   int m_acc = 0;
   int m_out = 0;
   bit m_after_rst = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // -------------------------------------------------------------------------------------------
   // Monitor / model: outputs are checked against the model state, then the model advances using
   // the inputs the next rising edge will see.
   // -------------------------------------------------------------------------------------------
   always @(negedge clk) begin
      int need;
      int exp_ir;
      int exp_wv;
      int act_win;
      bit aborted;
      if (rst) begin
         m_state     = M_IDLE;
         m_acc       = 0;
         m_out       = 0;
         m_after_rst = 1'b1;
         exp_q.delete();
      end else begin
         if (done) done_cnt++;
         case (m_state)
            M_IDLE: begin
               check("idle_busy", busy, 0);
               check("idle_done", done, 0);
               check("idle_in_ready", in_ready, 0);
               check("idle_win_valid", win_valid, 0);
               check("idle_corner", corner_type, 0);
               if (m_after_rst) begin
                  check("rst_wr_idx", wr_idx, 0);
                  check("rst_win_row", win_row, 0);
                  check("rst_win_col", win_col, 0);
               end
               if (start) begin
                  m_state = M_RUN;
                  m_acc   = 0;
                  m_out   = 0;
               end
            end
            M_RUN: begin
               need = m_out + W + (((m_out % W) == W - 1) ? 1 : 2);
               if (need > N) need = N;
               exp_ir = ((m_acc < N) && (m_acc + W + 1 < m_out + D)) ? 1 : 0;
               exp_wv = (m_acc >= need) ? 1 : 0;
               check("run_busy", busy, 1);
               check("run_done", done, 0);
               check("in_ready", in_ready, exp_ir);
               check("win_valid", win_valid, exp_wv);
               check("wr_idx", wr_idx, m_acc);
               if (exp_wv != 0) begin
                  check("win_queue_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
                  if (exp_q.size() > 0) begin
                     act_win = int'(win_row) * 256 + int'(win_col) * 16 + int'(corner_type);
                     check("window", act_win, exp_q[0]);
                  end
               end
               aborted = 1'b0;
`ifdef GAUSS_CTRL_ABORT_EN
               if (abort) begin
                  aborted = 1'b1;
                  m_state = M_IDLE;
                  exp_q.delete();
               end
`endif
               if (!aborted) begin
                  if (in_valid && exp_ir != 0) m_acc++;
                  if (exp_wv != 0 && win_ready) begin
                     if (exp_q.size() > 0) void'(exp_q.pop_front());
                     m_out++;
                     if (m_out == N) m_state = M_DONE;
                  end
               end
            end
            default: begin
               check("done_pulse", done, 1);
               check("done_busy", busy, 0);
               check("done_in_ready", in_ready, 0);
               check("done_win_valid", win_valid, 0);
               check("done_corner", corner_type, 0);
               m_state = M_IDLE;
            end
         endcase
         m_after_rst = 1'b0;
      end
   end

   // -------------------------------------------------------------------------------------------
   // Stimulus
   // -------------------------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_start();
      for (int k = 0; k < N; k++) begin
         exp_q.push_back((k / W) * 256 + (k % W) * 16 + corner_tab[k]);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // iv_mode: 0 always, 1 every other cycle, 2 random.
   // wr_mode: 0 always, 1 random, 2 held low for 20 cycles.
   // evt: start during RUN and DONE, abort pulse at window 3.
   task automatic drive_frame(input int iv_mode, input int wr_mode, input bit evt,
                              input int limit);
      bit abort_sent;
      abort_sent = 1'b0;
      for (int i = 0; i < limit; i++) begin
         case (iv_mode)
            0:       in_valid = 1'b1;
            1:       in_valid = (i % 2) == 0;
            default: in_valid = 1'($urandom_range(0, 1));
         endcase
         case (wr_mode)
            0:       win_ready = 1'b1;
            1:       win_ready = 1'($urandom_range(0, 1));
            default: win_ready = (i >= 20);
         endcase
         start = evt && (i == 4 || done);
         abort = 1'b0;
         if (evt && !abort_sent && m_state == M_RUN && m_out == 3) begin
            abort      = 1'b1;
            abort_sent = 1'b1;
         end
         tick();
         if (m_state == M_IDLE) break;
      end
      start     = 1'b0;
      abort     = 1'b0;
      in_valid  = 1'b0;
      win_ready = 1'b0;
      check("frame_end_busy", busy, 0);
   endtask

   initial begin
      int exp_done;
      rst       = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      in_valid  = 1'b0;
      win_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();

      // Full-rate frame.
      issue_start();
      drive_frame(0, 0, 1'b0, 200);
      tick();

      // Stalled source.
      issue_start();
      drive_frame(1, 0, 1'b0, 200);
      tick();

      // Random source and sink.
      issue_start();
      drive_frame(2, 1, 1'b0, 400);
      tick();

      // Backpressure: sink held off; throttle stops after 7 pixels.
      issue_start();
      in_valid  = 1'b1;
      win_ready = 1'b0;
      repeat (20) tick();
      check("bp_accepted", wr_idx, 7);
      check("bp_in_ready", in_ready, 0);
      check("bp_win_valid", win_valid, 1);
      check("bp_win_pos", {win_row, win_col}, 4'h0);
      win_ready = 1'b1;
      tick();
      win_ready = 1'b0;
      repeat (3) tick();
      check("bp_one_more", wr_idx, 8);
      drive_frame(0, 0, 1'b0, 200);
      tick();

      // Reset mid-frame after 5 accepts, then a clean replay.
      issue_start();
      in_valid  = 1'b1;
      win_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (wr_idx == IDX_W'(5)) break;
         tick();
      end
      check("pre_rst_wr_idx", wr_idx, 5);
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      in_valid  = 1'b0;
      win_ready = 1'b0;
      tick();
      check("post_rst_busy", busy, 0);
      check("post_rst_wr_idx", wr_idx, 0);
      check("post_rst_win_valid", win_valid, 0);
      issue_start();
      drive_frame(0, 0, 1'b0, 200);
      tick();

      // Start during RUN/DONE and abort pulse at window 3.
      issue_start();
      drive_frame(2, 0, 1'b1, 400);
      repeat (3) tick();

`ifdef GAUSS_CTRL_ABORT_EN
      exp_done = 5;
`else
      exp_done = 6;
`endif
      check("done_count", done_cnt, exp_done);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
